// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM requester arbiter.
package psram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 23;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = DATA_W / 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: the port after last_grant has highest priority.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         last_grant,
  output logic [1:0]         winner,
  output logic               any_valid
);

  // Scan last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); the first valid port wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int off = 1; off <= int'(NUM_REQ); off++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!any_valid && req_valid[i] &&
            ((int'(last_grant) + off) % int'(NUM_REQ)) == i) begin
          winner    = 2'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one qqspi PSRAM controller among NUM_REQ requesters.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      mem_valid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [STRB_W-1:0]         mem_wstrb,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [1:0]                grant_id,
  output logic                      busy
);

  arb_state_e          state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          winner;
  logic                any_valid;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .last_grant(last_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // State and registered outputs; last grant resets to the top port so port 0 wins first.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      req_ready_q <= '0;
      req_rdata_q <= '0;
      grant_q     <= '0;
      last_q      <= 2'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      req_ready_q <= req_ready_d;
      req_rdata_q <= req_rdata_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

  // Next-state: grant in idle, wait for mem_ready, then wait for it to drop before re-arbitrating.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    req_ready_d = '0;
    req_rdata_d = req_rdata_q;
    grant_d     = grant_q;
    last_d      = last_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == 2'(i)) begin
              mem_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              mem_wdata_d = req_wdata[i*DATA_W +: DATA_W];
              mem_wstrb_d = req_wstrb[i*STRB_W +: STRB_W];
            end
          end
          mem_valid_d = 1'b1;
          grant_d     = winner;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          req_rdata_d = mem_rdata;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == 2'(i)) req_ready_d[i] = 1'b1;
          end
          last_d  = grant_q;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // The controller holds ready until it sees mem_valid low; wait it out.
        if (!mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign req_ready = req_ready_q;
  assign req_rdata = req_rdata_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_psram_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 23;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*32-1:0] req_wdata = '0;
  logic [NR*4-1:0]  req_wstrb = '0;
  logic [31:0]      req_rdata;
  logic             mem_valid;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_ready = 1'b0;
  logic [31:0]      mem_rdata = '0;
  logic [1:0]       grant_id;
  logic             busy;

  always #5 clk = ~clk;

  psram_arbiter #(
    .NUM_REQ(NR),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .req_rdata(req_rdata),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: transaction view of the arbiter.
  bit            m_inflight, m_wait_low;
  int            m_last;
  logic          exp_valid;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wdata, exp_rdata;
  logic [3:0]    exp_wstrb;
  logic [1:0]    exp_grant;
  logic [NR-1:0] exp_ready;
  int            grants[$];
  int            mm_lat = 3, mm_hold = 0;

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= int'(NR); k++) begin
      int p = (last + k) % int'(NR);
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_wait_low = 0; m_last = NR - 1;
    exp_valid = 0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
    exp_rdata = '0; exp_grant = '0; exp_ready = '0;
  endtask

  // Apply the rules to the inputs sampled at the edge just taken.
  task automatic model_edge();
    exp_ready = '0;
    if (resetn) begin
      model_reset();
    end else if (m_inflight) begin
      if (mem_ready) begin
        exp_valid = 0;
        exp_rdata = mem_rdata;
        exp_ready[exp_grant] = 1'b1;
        m_last = int'(exp_grant);
        m_inflight = 0;
        m_wait_low = 1;
      end
    end else if (m_wait_low) begin
      if (!mem_ready) m_wait_low = 0;
    end else begin
      int w = rr_pick(req_valid, m_last);
      if (w >= 0) begin
        exp_valid = 1;
        exp_addr  = req_addr[w*AW +: AW];
        exp_wdata = req_wdata[w*32 +: 32];
        exp_wstrb = req_wstrb[w*4 +: 4];
        exp_grant = 2'(w);
        m_inflight = 1;
        grants.push_back(w);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_eq("mem_valid", mem_valid, exp_valid);
    check_eq("mem_addr", mem_addr, exp_addr);
    check_eq("mem_wdata", mem_wdata, exp_wdata);
    check_eq("mem_wstrb", mem_wstrb, exp_wstrb);
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("req_rdata", req_rdata, exp_rdata);
    check_eq("grant_id", grant_id, exp_grant);
    check_eq("busy", busy, m_inflight || m_wait_low);
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    req_addr[i*AW +: AW] = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4] = s;
  endtask

  task automatic new_req(input int i);
    set_port(i, AW'($urandom), $urandom, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom));
  endtask

  // Wait for a grant, answer after lat cycles, hold ready for hold cycles after completion.
  task automatic finish_txn(input int lat, input int hold, input bit keep);
    int budget = 0;
    int p;
    while (!mem_valid && budget < 50) begin
      step();
      budget++;
    end
    check_eq("grant_seen", mem_valid, 1);
    if (mem_valid) begin
      repeat (lat) step();
      p = int'(exp_grant);
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      step();
      if (keep) new_req(p);
      else req_valid[p] = 1'b0;
      repeat (hold) step();
      mem_ready = 1'b0;
      step();
    end
  endtask

  // Random requesters and a controller that answers with random latency and ready tail.
  task automatic rand_drive(input bit allow_new);
    for (int i = 0; i < int'(NR); i++) begin
      if (req_valid[i] && exp_ready[i]) begin
        if (!allow_new || $urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
        else new_req(i);
      end else if (!req_valid[i]) begin
        new_req(i);
        if (allow_new && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
      end else if (m_inflight && int'(exp_grant) == i && $urandom_range(0, 3) == 0) begin
        new_req(i);
      end
    end
    mem_rdata = $urandom;
    if (mem_ready) begin
      if (!mem_valid) begin
        if (mm_hold == 0) mem_ready = 1'b0;
        else mm_hold--;
      end
    end else if (mem_valid) begin
      if (mm_lat == 0) begin
        mem_ready = 1'b1;
        mm_hold = $urandom_range(0, 3);
        mm_lat = $urandom_range(0, 6);
      end else begin
        mm_lat--;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      mem_ready = 1'b1;
      mm_hold = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int exp_seq[4] = '{0, 1, 0, 1};
    int budget;
    model_reset();

    // Reset values, then a single port-0 read with a 20-cycle controller.
    repeat (2) step();
    resetn = 1'b0;
    set_port(0, 23'h000010, 32'h0, 4'h0);
    req_valid = 3'b001;
    step();
    check_eq("t1_valid_next_cycle", mem_valid, 1);
    repeat (19) step();
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    check_eq("t1_ready_pulse", req_ready, 3'b001);
    check_eq("t1_rdata", req_rdata, 32'hCAFEF00D);
    // Port 0 asks again while the controller keeps ready high for 3 cycles.
    set_port(0, 23'h000011, 32'h0, 4'h0);
    repeat (3) begin
      step();
      check_eq("t1_drain_no_valid", mem_valid, 0);
      check_eq("t1_drain_busy", busy, 1);
    end
    mem_ready = 1'b0;
    step();
    finish_txn(1, 0, 0);

    // Two ports valid at reset release: round robin alternates.
    resetn = 1'b1;
    step();
    new_req(0);
    new_req(1);
    req_valid = 3'b011;
    resetn = 1'b0;
    grants.delete();
    repeat (4) finish_txn(2, 0, 1);
    for (int i = 0; i < 4; i++) check_eq("rr_seq", grants[i], exp_seq[i]);

    // Port 1 write; its inputs change during the transaction but mem_* must not.
    resetn = 1'b1;
    step();
    req_valid = '0;
    resetn = 1'b0;
    set_port(1, 23'h200000, 32'h0000BEEF, 4'b0011);
    req_valid = 3'b010;
    step();
    check_eq("t3_wstrb", mem_wstrb, 4'b0011);
    check_eq("t3_wdata", mem_wdata, 32'h0000BEEF);
    check_eq("t3_addr", mem_addr, 23'h200000);
    set_port(1, 23'h001234, 32'h12345678, 4'b1111);
    finish_txn(6, 1, 0);

    // Reset 5 cycles into a port-1 transaction: no pulse, port 0 wins afterwards.
    new_req(0);
    req_valid = 3'b001;
    finish_txn(1, 0, 0);
    new_req(0);
    new_req(1);
    req_valid = 3'b011;
    step();
    check_eq("t4_grant_p1", grant_id, 2'd1);
    repeat (5) step();
    resetn = 1'b1;
    #1;
    check_eq("t4_rst_valid", mem_valid, 0);
    check_eq("t4_rst_ready", req_ready, 0);
    model_reset();
    repeat (2) step();
    resetn = 1'b0;
    step();
    check_eq("t4_post_rst_grant", grant_id, 2'd0);
    finish_txn(1, 0, 0);
    finish_txn(1, 0, 0);

    // Randomized traffic, then let outstanding requests drain.
    repeat (3000) begin
      step();
      rand_drive(1'b1);
    end
    budget = 0;
    while ((req_valid != '0 || busy) && budget < 300) begin
      step();
      rand_drive(1'b0);
      budget++;
    end
    check_eq("drained_valid", req_valid, 0);
    check_eq("drained_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requester ports (legal 2..4).
REQ-002 Parameter ADDR_W, default 23, word address width (8Mx32 space).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-high (port name kept per codebase).
REQ-005 req_valid  input  NUM_REQ  per-port request strobe, held until that port's req_ready.
REQ-006 req_ready  output  NUM_REQ  per-port one-cycle completion pulse.
REQ-007 req_addr  input  NUM_REQ*ADDR_W  flattened per-port word addresses, port i at [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  input  NUM_REQ*32  flattened per-port write data.
REQ-009 req_wstrb  input  NUM_REQ*4  flattened per-port byte strobes; 0 = read.
REQ-010 req_rdata  output  32  read data, shared by all ports, valid with the req_ready pulse.
REQ-011 mem_valid, mem_addr[ADDR_W], mem_wdata[32], mem_wstrb[4]  output  request to the qqspi controller.
REQ-012 mem_ready  input  1; mem_rdata  input  32  qqspi response (ready level-held until mem_valid drops).
REQ-013 grant_id  output  2  index of current/last granted port; busy  output  1  high outside IDLE.

Function
REQ-014 FSM states: IDLE, REQ, DRAIN.
REQ-015 IDLE, any req_valid high: choose winner round-robin, priority order last_grant+1, last_grant+2, ... , last_grant (mod NUM_REQ).
REQ-016 On grant: register winner's addr/wdata/wstrb into mem_*, set mem_valid=1, grant_id=winner, busy=1, go REQ; mem_valid rises the cycle after req_valid is sampled.
REQ-017 REQ: mem_valid and mem_* held constant; requester inputs ignored.
REQ-018 REQ with mem_ready=1: mem_valid<=0, req_rdata<=mem_rdata, req_ready[grant_id]<=1 for exactly one cycle, last_grant<=grant_id, go DRAIN.
REQ-019 DRAIN: req_ready cleared; remain until mem_ready=0, then go IDLE (busy=0); DRAIN lasts at least one cycle.
REQ-020 req_rdata holds its value until the next completion; writes also update it with mem_rdata.
REQ-021 At most one req_ready bit high in any cycle; never high outside the cycle after mem_ready is seen in REQ.
REQ-022 Requests arriving while not IDLE wait; no request is dropped; a port holding valid is granted within NUM_REQ transactions.
REQ-023 Ports with req_valid low are skipped; a single requester is granted back-to-back without penalty beyond DRAIN.
REQ-024 mem_ready high while in IDLE is ignored (no grant side effects).

Reset
REQ-025 Async assert: state=IDLE, mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0, req_ready=0, req_rdata=0, grant_id=0, busy=0, last_grant=NUM_REQ-1 (port 0 wins first).
REQ-026 Reset mid-transaction drops mem_valid immediately; in-flight request is lost, no req_ready pulse issued.

Structure
REQ-027 Shared package psram_arb_pkg: state encoding, ADDR_W default 23, DATA_W 32.
REQ-028 One sub-module rr_picker: combinational winner index + any_valid from req_valid and last_grant.

Verification
REQ-029 Port 0 read addr 0x000010, mem model ready after 20 cycles with rdata 0xCAFEF00D -> mem_valid 1 cycle after req_valid, req_ready[0] single pulse, req_rdata=0xCAFEF00D.
REQ-030 Ports 0,1 both valid at reset release -> grants 0,1,0,1 on repeated requests; grant_id sequence matches.
REQ-031 Port 1 write wstrb=4'b0011 wdata=0x0000BEEF addr 0x200000 -> mem_wstrb=0011, mem_wdata=0x0000BEEF, mem_addr=0x200000 stable throughout REQ.
REQ-032 Port 0 changes req_addr during REQ -> mem_addr unchanged until completion.
REQ-033 Reset asserted 5 cycles into REQ -> mem_valid=0 same cycle, no req_ready, next grant goes to port 0.
REQ-034 mem model holds ready 3 cycles after mem_valid drops -> DRAIN held 3 cycles, no new mem_valid until mem_ready=0.
